// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - KS0108 frame scheduler: periodic driver start, ping-pong bank swap, arm watchdog
// Optional build macro FRAME_STATS_EN adds saturating frames_o / drops_o counters.
module lcd_frame_scheduler #(
  parameter int TICK_DIV  = 100000,
  parameter int START_LEN = 4,
  parameter int ARM_TO    = 64,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [2:0]  drv_state_i,
  input  logic [9:0]  drv_addr_i,
  output logic        drv_start_o,
  output logic [10:0] rd_addr_o,
  input  logic [9:0]  rdr_addr_i,
  input  logic        rdr_we_i,
  input  logic [7:0]  rdr_wdata_i,
  input  logic        rdr_done_i,
  output logic [10:0] wr_addr_o,
  output logic        wr_en_o,
  output logic [7:0]  wr_data_o,
  output logic        rdr_buf_o,
  output logic        swap_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        err_o
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] frames_o,
  output logic [15:0] drops_o
`endif
);

  localparam int SC_W = (START_LEN > 2) ? $clog2(START_LEN) : 1;
  localparam int AC_W = (ARM_TO > 2) ? $clog2(ARM_TO) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_LEN - 1);
  localparam logic [AC_W-1:0]  ARM_LAST   = AC_W'(ARM_TO - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [SC_W-1:0]   r_start_cnt;
  logic [AC_W-1:0]   r_arm_cnt;
  logic              r_arm;
  logic              r_front;
  logic              r_pending;
  logic              r_drv_start;
  logic              r_busy;
  logic              r_swap;
  logic              r_frame_done;
  logic              r_err;

  logic              w_tick;
  logic              w_halt;
  logic              w_go;
  logic              w_swap;
  logic              w_done;
  logic              w_timeout;
  logic              w_start_nxt;
  logic              w_busy_nxt;

  assign w_tick = (r_tick_cnt == TICK_LAST);
  assign w_halt = (drv_state_i == 3'd7);
  // A frame may only begin on a tick, from WAIT, with the driver parked in HALT.
  assign w_go   = (r_state == ST_WAIT) & w_tick & enable_i & w_halt;
  // Swaps ride on the frame start so the driver always scans a whole bank.
  assign w_swap = w_go & r_pending;

  // Free-running frame period counter, independent of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; also flags frame completion and arm timeout.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_go) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (r_start_cnt == '0) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_arm && w_halt) begin
          w_done       = 1'b1;
          w_next_state = ST_WAIT;
        end else if (!r_arm && w_halt && (r_arm_cnt == ARM_LAST)) begin
          w_timeout    = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_WAIT;
      end
    endcase
  end

  // FSM output decode, computed from the next state so the outputs are registered.
  always_comb begin
    w_start_nxt = (w_next_state == ST_START);
    w_busy_nxt  = (w_next_state == ST_START) | (w_next_state == ST_RUN);
  end

  // Start-pulse length counter and the arm watchdog (driver must leave HALT in time).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_cnt <= '0;
      r_arm       <= 1'b0;
      r_arm_cnt   <= '0;
    end else begin
      if (w_go) begin
        r_start_cnt <= START_LAST;
      end else if ((r_state == ST_START) && (r_start_cnt != '0)) begin
        r_start_cnt <= r_start_cnt - 1'b1;
      end
      if (r_state != ST_RUN) begin
        r_arm     <= 1'b0;
        r_arm_cnt <= '0;
      end else if (!r_arm) begin
        if (!w_halt) begin
          r_arm <= 1'b1;
        end else begin
          r_arm_cnt <= r_arm_cnt + 1'b1;
        end
      end
    end
  end

  // Registered status outputs; err is sticky until enable is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_swap       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_drv_start  <= w_start_nxt;
      r_busy       <= w_busy_nxt;
      r_swap       <= w_swap;
      r_frame_done <= w_done;
      r_err        <= enable_i & (r_err | w_timeout);
    end
  end

  // Bank ownership: a done pulse arriving on the swap edge is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_swap) begin
      r_front   <= ~r_front;
      r_pending <= 1'b0;
    end else if (rdr_done_i) begin
      r_pending <= 1'b1;
    end
  end

  assign drv_start_o  = r_drv_start;
  assign busy_o       = r_busy;
  assign swap_o       = r_swap;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;
  assign rdr_buf_o    = ~r_front;
  assign rd_addr_o    = {r_front, drv_addr_i};
  assign wr_addr_o    = {~r_front, rdr_addr_i};
  // The completed back bank is frozen until it becomes the front bank.
  assign wr_en_o      = rdr_we_i & ~r_pending;
  assign wr_data_o    = rdr_wdata_i;

`ifdef FRAME_STATS_EN
  logic [15:0] r_frames;
  logic [15:0] r_drops;
  logic        w_drop;

  assign w_drop = w_tick & enable_i & ~w_go;

  // Saturating frame and dropped-tick counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames <= '0;
      r_drops  <= '0;
    end else begin
      if (r_frame_done && (r_frames != 16'hFFFF)) begin
        r_frames <= r_frames + 1'b1;
      end
      if (w_drop && (r_drops != 16'hFFFF)) begin
        r_drops <= r_drops + 1'b1;
      end
    end
  end

  assign frames_o = r_frames;
  assign drops_o  = r_drops;
`endif

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - self-checking bench for lcd_frame_scheduler
module tb_lcd_frame_scheduler;
  localparam int TD = 3000;
  localparam int SL = 4;
  localparam int AT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  drv_state_i = 3'd7;
  logic [9:0]  drv_addr_i = '0;
  logic        drv_start_o;
  logic [10:0] rd_addr_o;
  logic [9:0]  rdr_addr_i = '0;
  logic        rdr_we_i = 1'b0;
  logic [7:0]  rdr_wdata_i = '0;
  logic        rdr_done_i = 1'b0;
  logic [10:0] wr_addr_o;
  logic        wr_en_o;
  logic [7:0]  wr_data_o;
  logic        rdr_buf_o;
  logic        swap_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        err_o;
`ifdef FRAME_STATS_EN
  logic [15:0] frames_o;
  logic [15:0] drops_o;
`endif

  lcd_frame_scheduler #(.TICK_DIV(TD), .START_LEN(SL), .ARM_TO(AT), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .drv_state_i(drv_state_i),
    .drv_addr_i(drv_addr_i), .drv_start_o(drv_start_o), .rd_addr_o(rd_addr_o),
    .rdr_addr_i(rdr_addr_i), .rdr_we_i(rdr_we_i), .rdr_wdata_i(rdr_wdata_i),
    .rdr_done_i(rdr_done_i), .wr_addr_o(wr_addr_o), .wr_en_o(wr_en_o),
    .wr_data_o(wr_data_o), .rdr_buf_o(rdr_buf_o), .swap_o(swap_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
`ifdef FRAME_STATS_EN
    , .frames_o(frames_o), .drops_o(drops_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // environment (behavioural driver + renderer)
  bit en_req = 1'b0;
  bit never_leave = 1'b0;
  bit force_done = 1'b0;
  bit prev_start = 1'b0;
  int scan_len = 2120;
  int leave_at = 0;
  int back_at = 0;

  // reference model: frame schedule in absolute cycle numbers
  bit m_active, m_left, m_front, m_pending, m_err;
  int m_T, m_done_at, m_swap_at;
`ifdef FRAME_STATS_EN
  int m_frames, m_drops;
`endif

  typedef struct {
    logic [9:0]  drv_addr;
    logic [9:0]  rdr_addr;
    logic        we;
    logic [7:0]  wdata;
    logic [10:0] exp_rd;
    logic [10:0] exp_wr;
    logic        exp_we;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_left = 0; m_front = 0; m_pending = 0; m_err = 0;
    m_T = -100; m_done_at = -1; m_swap_at = -1;
`ifdef FRAME_STATS_EN
    m_frames = 0; m_drops = 0;
`endif
    prev_start = 0; leave_at = 0; back_at = 0;
  endtask

  // Hold reset, release it on a falling edge; the released interval is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rdr_done_i = 1'b0; drv_state_i = 3'd7; rdr_we_i = 1'b0; enable_i = en_req;
    rst = 1'b0;
    model_reset();
    cyc = 1;
  endtask

  task automatic step();
    bit cur_start, tick, halt, start_now, timeout;
    @(negedge clk);
    cur_start = drv_start_o;
    if (prev_start && !cur_start && !never_leave) begin
      leave_at = cyc + 3;
      back_at  = cyc + 3 + scan_len;
    end
    prev_start  = cur_start;
    drv_state_i = (cyc >= leave_at && cyc < back_at) ? 3'($urandom_range(0, 6)) : 3'd7;
    enable_i    = en_req;
    drv_addr_i  = 10'($urandom);
    rdr_addr_i  = 10'($urandom);
    rdr_wdata_i = 8'($urandom);
    rdr_we_i    = 1'($urandom);
    rdr_done_i  = force_done | ($urandom_range(0, 1499) == 0);
    force_done  = 1'b0;
    #1;
    check("drv_start_o", 32'(drv_start_o), 32'(m_active && cyc <= m_T + SL));
    check("busy_o", 32'(busy_o), 32'(m_active));
    check("swap_o", 32'(swap_o), 32'(cyc == m_swap_at));
    check("frame_done_o", 32'(frame_done_o), 32'(cyc == m_done_at));
    check("err_o", 32'(err_o), 32'(m_err));
    check("rdr_buf_o", 32'(rdr_buf_o), 32'(!m_front));
    check("rd_addr_o", 32'(rd_addr_o), 32'({m_front, drv_addr_i}));
    check("wr_addr_o", 32'(wr_addr_o), 32'({!m_front, rdr_addr_i}));
    check("wr_en_o", 32'(wr_en_o), 32'(rdr_we_i && !m_pending));
    check("wr_data_o", 32'(wr_data_o), 32'(rdr_wdata_i));
`ifdef FRAME_STATS_EN
    check("frames_o", 32'(frames_o), 32'(m_frames));
    check("drops_o", 32'(drops_o), 32'(m_drops));
    if (cyc == m_done_at && m_frames < 65535) m_frames++;
`endif
    tick      = (cyc % TD) == (TD - 1);
    halt      = (drv_state_i == 3'd7);
    timeout   = 0;
    start_now = !m_active && tick && enable_i && halt;
`ifdef FRAME_STATS_EN
    if (tick && enable_i && !start_now && m_drops < 65535) m_drops++;
`endif
    if (m_active && cyc >= m_T + SL + 1) begin
      if (m_left && halt) begin
        m_done_at = cyc + 1;
        m_active  = 0;
      end else if (!m_left && !halt) begin
        m_left = 1;
      end else if (!m_left && cyc == m_T + SL + AT) begin
        timeout  = 1;
        m_active = 0;
      end
    end
    if (start_now) begin
      m_active = 1; m_T = cyc; m_left = 0;
      if (m_pending) begin
        m_front   = !m_front;
        m_pending = 0;
        m_swap_at = cyc + 1;
      end else if (rdr_done_i) begin
        m_pending = 1;
      end
    end else if (rdr_done_i) begin
      m_pending = 1;
    end
    if (!enable_i) m_err = 0;
    else if (timeout) m_err = 1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model is `depth` cycles into a started frame; expiry counts as a failure.
  task automatic run_into_frame(input int depth);
    int k;
    k = 0;
    while (!(m_active && cyc == m_T + depth) && k < 7000) begin
      step();
      k++;
    end
    check("frame_reached", 32'(k < 7000), 32'd1);
  endtask

  task automatic async_reset_check();
    #2;
    rst = 1'b1;
    #1;
    check("rst_drv_start", 32'(drv_start_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rdr_buf", 32'(rdr_buf_o), 32'd1);
    check("rst_front_addr", 32'(rd_addr_o[10]), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    do_reset();
  endtask

  initial begin
    tbl[0] = '{10'h000, 10'h000, 1'b0, 8'h00, 11'h000, 11'h400, 1'b0};
    tbl[1] = '{10'h3FF, 10'h155, 1'b1, 8'hA5, 11'h3FF, 11'h555, 1'b1};
    tbl[2] = '{10'h2AA, 10'h3FF, 1'b1, 8'hFF, 11'h2AA, 11'h7FF, 1'b1};
    tbl[3] = '{10'h001, 10'h200, 1'b0, 8'h3C, 11'h001, 11'h600, 1'b0};
    tbl[4] = '{10'h13F, 10'h040, 1'b1, 8'h00, 11'h13F, 11'h440, 1'b1};

    // reset state and bank-address datapath (front=0, nothing pending)
    do_reset();
    @(negedge clk);
    check("reset_drv_start", 32'(drv_start_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_swap", 32'(swap_o), 32'd0);
    check("reset_done", 32'(frame_done_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_rdr_buf", 32'(rdr_buf_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_addr_i = tbl[i].drv_addr; rdr_addr_i = tbl[i].rdr_addr;
      rdr_we_i = tbl[i].we; rdr_wdata_i = tbl[i].wdata;
      #1;
      check("tbl_rd_addr", 32'(rd_addr_o), 32'(tbl[i].exp_rd));
      check("tbl_wr_addr", 32'(wr_addr_o), 32'(tbl[i].exp_wr));
      check("tbl_wr_en", 32'(wr_en_o), 32'(tbl[i].exp_we));
      check("tbl_wr_data", 32'(wr_data_o), 32'(tbl[i].wdata));
    end
    // done pulse freezes writes from the next cycle; no swap without a frame start
    @(negedge clk);
    rdr_done_i = 1'b1; rdr_we_i = 1'b1;
    #1;
    check("done_cycle_wr_en", 32'(wr_en_o), 32'd1);
    @(negedge clk);
    rdr_done_i = 1'b0;
    #1;
    check("pending_wr_en", 32'(wr_en_o), 32'd0);
    check("pending_rdr_buf", 32'(rdr_buf_o), 32'd1);

    // normal frames with directed done pulses (second one while pending)
    en_req = 1'b1;
    do_reset();
    run(4000);
    force_done = 1'b1;
    run(300);
    force_done = 1'b1;
    run(8000);

    // driver never leaves HALT: arm timeout, then err clears with enable low
    never_leave = 1'b1;
    run(3100);
    en_req = 1'b0;
    run(60);
    never_leave = 1'b0;
    en_req = 1'b1;

    // scan longer than the frame period: alternate ticks dropped
    scan_len = 3100;
    run(12000);
    scan_len = 2120;

    // random enable toggling, frames complete after enable falls
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 499) == 0) en_req = !en_req;
      step();
    end
    en_req = 1'b1;

    // async reset during START, then during RUN after a forced swap
    run_into_frame(2);
    async_reset_check();
    force_done = 1'b1;
    run_into_frame(40);
    async_reset_check();
    run(3200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
Frame-level controller for the KS0108-style 128x64 LCD driver. It generates periodic start pulses for the driver and owns a ping-pong pair of 1 KB graphic banks, one front (read by the driver) and one back (written by the game renderer). Bank swaps happen only at frame boundaries, so the driver never scans a half-drawn frame.

Parameters:
TICK_DIV, 100000, clk cycles per frame period (>= 2200; one full driver scan is about 2120 cycles)
START_LEN, 4, cycles drv_start_o is held high (>= 2, so the driver's falling-edge detector sees it)
ARM_TO, 64, cycles allowed after start for the driver to leave HALT before an error is flagged
CNT_W, 17, width of the tick counter (must cover TICK_DIV-1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-high reset
enable_i  in  1  1 = issue frames on ticks
drv_state_i  in  3  driver state; 3'd7 = HALT
drv_addr_i  in  10  driver read address {x[3:0],y[5:0]}
drv_start_o  out  1  to driver start_i
rd_addr_o  out  11  RAM read port address = {front, drv_addr_i}, combinational
rdr_addr_i  in  10  renderer write address
rdr_we_i  in  1  renderer write strobe
rdr_wdata_i  in  8  renderer write data
rdr_done_i  in  1  one-cycle pulse: back bank complete
wr_addr_o  out  11  RAM write port address = {~front, rdr_addr_i}
wr_en_o  out  1  rdr_we_i & ~pending
wr_data_o  out  8  rdr_wdata_i passthrough
rdr_buf_o  out  1  current back bank index (= ~front)
swap_o  out  1  one-cycle pulse: banks swapped, renderer may draw the new back bank
frame_done_o  out  1  one-cycle pulse: driver returned to HALT after a scan
busy_o  out  1  1 in START or RUN
err_o  out  1  sticky arm-timeout flag

Behaviour:
- Reset values: front=0, rdr_buf_o=1, pending=0, state=WAIT, tick_cnt=0, drv_start_o=0, swap_o=0, frame_done_o=0, busy_o=0, err_o=0.
- tick_cnt free-runs 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle, when tick_cnt==TICK_DIV-1. It runs in every state.
- pending: set by rdr_done_i, cleared by a swap. rdr_done_i while pending=1 is ignored. If rdr_done_i coincides with the swap cycle, the swap clears pending and that done pulse is discarded.
- Write protection: wr_en_o=0 whenever pending=1, so the completed frame is frozen.
- FSM states: WAIT, START, RUN.
- WAIT:
  - Entry condition: tick & enable_i & drv_state_i==7.
  - Next cycle: state=START, drv_start_o=1, start counter loaded.
  - If pending is set on that same edge: front toggles, pending clears, swap_o=1 for one cycle.
- START:
  - drv_start_o held 1 for exactly START_LEN cycles, then drops to 0; state becomes RUN and the arm counter clears.
- RUN:
  - arm=0 and drv_state_i!=7: set arm.
  - arm=0 and ARM_TO cycles elapse: err_o=1, state=WAIT, no frame_done_o.
  - arm=1 and drv_state_i==7: frame_done_o=1 for one cycle, state=WAIT.
- Dropped frames: a tick while state!=WAIT, enable_i=0, or drv_state_i!=7 is dropped. No start is issued and the swap is deferred.
- enable_i falling during START or RUN: the current frame completes normally, then the block idles in WAIT.
- err_o clears only on rst or while enable_i=0.
- Reset mid-frame: all state returns to reset values immediately. drv_start_o=0 asynchronously.
- busy_o = (state==START) | (state==RUN), registered.

Optional Feature:
FRAME_STATS_EN
- Defined: adds 16-bit outputs frames_o and drops_o.
  - frames_o increments on frame_done_o.
  - drops_o increments on each dropped tick while enable_i=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists.

Test Plan:
Common setup: TICK_DIV=3000, START_LEN=4, ARM_TO=64, behavioural driver leaving HALT 3 cycles after start falls and scanning 2120 cycles.
- Reset then enable_i=1 -> drv_start_o high 4 cycles starting the cycle after tick_cnt==2999; frame_done_o pulses once around 2127 cycles later; busy_o high in between.
- rdr_done_i pulse mid-scan -> wr_en_o=0 from the next cycle; at the next tick front 0->1, rd_addr_o[10]=1, rdr_buf_o=0, swap_o one pulse, pending=0.
- Second rdr_done_i while pending -> no extra swap; exactly one swap_o at the following tick.
- Driver model never leaves HALT -> err_o=1 64 cycles after drv_start_o falls; FSM returns to WAIT; err_o clears after enable_i=0.
- TICK_DIV=2200 with a 2300-cycle driver scan -> alternate ticks dropped, no start during RUN; with FRAME_STATS_EN, drops_o increments per dropped tick.
- Assert rst during RUN -> drv_start_o, busy_o=0 and front=0 immediately; the next frame starts cleanly after release.
